// File: rtl/rx_fifo_pkg.sv
// rx_frame_fifo shared types: RAM entry layout
// and write-side FSM state encoding.
package rx_fifo_pkg;

  localparam int ENTRY_W = 10;
  localparam int SOF_BIT = 9;
  localparam int EOF_BIT = 8;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_FRAME = 2'd1,
    W_DROP  = 2'd2
  } wr_state_e;

endpackage

// File: rtl/rx_frame_fifo_if.sv
// GMAC-side byte stream in, consumer stream out.
// DropCount exists only with RX_DROP_COUNT_EN.
interface rx_frame_fifo_if #(
  parameter int ADDR_W = 11
`ifdef RX_DROP_COUNT_EN
  , parameter int DROP_CNT_W = 16
`endif
);

  logic              SoFIn;
  logic              EoFIn;
  logic              EnaIn;
  logic              ErrIn;
  logic [7:0]        DataIn;
  logic              ValOut;
  logic              SoFOut;
  logic              EoFOut;
  logic [7:0]        DataOut;
  logic              RdyIn;
  logic              FrameAvail;
  logic [ADDR_W-1:0] Level;
`ifdef RX_DROP_COUNT_EN
  logic [DROP_CNT_W-1:0] DropCount;
`endif

`ifdef RX_DROP_COUNT_EN
  modport master (
    output SoFIn, EoFIn, EnaIn, ErrIn,
    output DataIn, RdyIn,
    input  ValOut, SoFOut, EoFOut,
    input  DataOut, FrameAvail, Level,
    input  DropCount
  );

  modport slave (
    input  SoFIn, EoFIn, EnaIn, ErrIn,
    input  DataIn, RdyIn,
    output ValOut, SoFOut, EoFOut,
    output DataOut, FrameAvail, Level,
    output DropCount
  );
`else
  modport master (
    output SoFIn, EoFIn, EnaIn, ErrIn,
    output DataIn, RdyIn,
    input  ValOut, SoFOut, EoFOut,
    input  DataOut, FrameAvail, Level
  );

  modport slave (
    input  SoFIn, EoFIn, EnaIn, ErrIn,
    input  DataIn, RdyIn,
    output ValOut, SoFOut, EoFOut,
    output DataOut, FrameAvail, Level
  );
`endif

endinterface

// File: rtl/rx_fifo_ram.sv
// Simple dual-port RAM, one write port and
// one registered read port that holds when re=0.
module rx_fifo_ram #(
  parameter int AW = 11,
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read; output holds between reads
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/rx_frame_fifo.sv
// Frame-committing RX byte FIFO behind the GMAC.
// RX_DROP_COUNT_EN adds the saturating DropCount.
module rx_frame_fifo
  import rx_fifo_pkg::*;
#(
  parameter int ADDR_W = 11
`ifdef RX_DROP_COUNT_EN
  , parameter int DROP_CNT_W = 16
`endif
) (
  input logic            CLK,
  input logic            RST,
  rx_frame_fifo_if.slave bus
);

  typedef logic [ADDR_W-1:0] ptr_t;
  localparam ptr_t ONE = ptr_t'(1);

  wr_state_e state_q, state_d;

  ptr_t wr_ptr, commit_ptr;
  ptr_t rd_ptr, fetch_ptr;
  ptr_t wr_ptr_d, commit_d, waddr;

  logic               we, drop, full;
  logic               re, ram_vld, stage_mv;
  logic               pop, out_vld;
  logic [ENTRY_W-1:0] wdata, rdata, out_q;

  // rd_ptr only moves on consumption, so
  // prefetched bytes stay protected too
  assign full  = (wr_ptr + ONE) == rd_ptr;
  assign wdata = {bus.SoFIn, bus.EoFIn, bus.DataIn};

  // write FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= W_IDLE;
    else     state_q <= state_d;
  end

  // write FSM next state
  always_comb begin
    state_d = state_q;
    if (bus.EnaIn) begin
      if (state_q == W_FRAME) begin
        if (full)
          state_d = bus.EoFIn ? W_IDLE : W_DROP;
        else if (bus.EoFIn)
          state_d = W_IDLE;
      end else if (bus.SoFIn) begin
        if (bus.EoFIn)
          state_d = W_IDLE;
        else
          state_d = full ? W_DROP : W_FRAME;
      end else if (bus.EoFIn) begin
        state_d = W_IDLE;
      end
    end
  end

  // write FSM outputs: RAM write, pointer moves, drops
  always_comb begin
    we       = 1'b0;
    waddr    = wr_ptr;
    wr_ptr_d = wr_ptr;
    commit_d = commit_ptr;
    drop     = 1'b0;
    if (bus.EnaIn) begin
      if (state_q == W_FRAME) begin
        priority case (1'b1)
          full: begin
            wr_ptr_d = commit_ptr;
            drop     = 1'b1;
          end
          bus.SoFIn: begin
            // unterminated frame: restart at commit_ptr
            drop = 1'b1;
            if (bus.EoFIn && bus.ErrIn) begin
              wr_ptr_d = commit_ptr;
            end else begin
              we       = 1'b1;
              waddr    = commit_ptr;
              wr_ptr_d = commit_ptr + ONE;
              if (bus.EoFIn)
                commit_d = commit_ptr + ONE;
            end
          end
          (bus.EoFIn && bus.ErrIn): begin
            wr_ptr_d = commit_ptr;
            drop     = 1'b1;
          end
          default: begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr + ONE;
            if (bus.EoFIn)
              commit_d = wr_ptr + ONE;
          end
        endcase
      end else if (bus.SoFIn) begin
        // idle/drop: wr_ptr already equals commit_ptr
        if (full || (bus.EoFIn && bus.ErrIn)) begin
          drop = 1'b1;
        end else begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr + ONE;
          if (bus.EoFIn)
            commit_d = wr_ptr + ONE;
        end
      end
    end
  end

  // write and commit pointers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
    end else begin
      wr_ptr     <= wr_ptr_d;
      commit_ptr <= commit_d;
    end
  end

`ifdef RX_DROP_COUNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt;

  // saturating count of discarded frames
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      drop_cnt <= '0;
    else if (drop && !(&drop_cnt))
      drop_cnt <= drop_cnt + 1'b1;
  end

  assign bus.DropCount = drop_cnt;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

  rx_fifo_ram #(
    .AW (ADDR_W),
    .DW (ENTRY_W)
  ) u_ram (
    .clk   (CLK),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (fetch_ptr),
    .rdata (rdata)
  );

  // RAM dout is a holding stage in front of out_q
  assign pop      = out_vld & bus.RdyIn;
  assign stage_mv = ram_vld & (~out_vld | pop);
  assign re       = (fetch_ptr != commit_ptr)
                  & (~ram_vld | stage_mv);

  // show-ahead read pipeline
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fetch_ptr <= '0;
      rd_ptr    <= '0;
      ram_vld   <= 1'b0;
      out_vld   <= 1'b0;
      out_q     <= '0;
    end else begin
      if (re)  fetch_ptr <= fetch_ptr + ONE;
      if (pop) rd_ptr    <= rd_ptr + ONE;
      if (re)
        ram_vld <= 1'b1;
      else if (stage_mv)
        ram_vld <= 1'b0;
      if (stage_mv) begin
        out_vld <= 1'b1;
        out_q   <= rdata;
      end else if (pop) begin
        out_vld <= 1'b0;
      end
    end
  end

  assign bus.ValOut     = out_vld;
  assign bus.SoFOut     = out_q[SOF_BIT];
  assign bus.EoFOut     = out_q[EOF_BIT];
  assign bus.DataOut    = out_q[7:0];
  assign bus.Level      = commit_ptr - rd_ptr;
  assign bus.FrameAvail = commit_ptr != rd_ptr;

endmodule

// File: tb/tb_rx_frame_fifo.sv
// Directed bench for rx_frame_fifo: a default
// instance and a 16-entry instance share stimulus.
module tb_rx_frame_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sof = 1'b0;
  logic       eof = 1'b0;
  logic       ena = 1'b0;
  logic       err = 1'b0;
  logic [7:0] din = 8'h00;
  logic       rdy_a = 1'b0;
  logic       rdy_b = 1'b0;

  int vec  = 0;
  int miss = 0;
  int cyc  = 0;

  logic [9:0] qa[$];
  int         ca[$];

  rx_frame_fifo_if #(.ADDR_W(11)) bus_a ();
  rx_frame_fifo_if #(.ADDR_W(4))  bus_b ();

  assign bus_a.SoFIn  = sof;
  assign bus_a.EoFIn  = eof;
  assign bus_a.EnaIn  = ena;
  assign bus_a.ErrIn  = err;
  assign bus_a.DataIn = din;
  assign bus_a.RdyIn  = rdy_a;
  assign bus_b.SoFIn  = sof;
  assign bus_b.EoFIn  = eof;
  assign bus_b.EnaIn  = ena;
  assign bus_b.ErrIn  = err;
  assign bus_b.DataIn = din;
  assign bus_b.RdyIn  = rdy_b;

  rx_frame_fifo #(.ADDR_W(11)) dut_a (
    .CLK (clk),
    .RST (rst),
    .bus (bus_a)
  );

  rx_frame_fifo #(.ADDR_W(4)) dut_b (
    .CLK (clk),
    .RST (rst),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // record every accepted beat of dut_a
  always @(negedge clk) begin
    if (bus_a.ValOut && rdy_a) begin
      qa.push_back({bus_a.SoFOut, bus_a.EoFOut,
                    bus_a.DataOut});
      ca.push_back(cyc);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    ena = 1'b0; sof = 1'b0; eof = 1'b0;
    err = 1'b0; din = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    qa.delete();
    ca.delete();
  endtask

  task automatic send_frame(input int n,
                            input logic [7:0] base,
                            input logic e,
                            input logic has_eof);
    for (int i = 0; i < n; i++) begin
      ena = 1'b1;
      sof = (i == 0);
      eof = has_eof && (i == n - 1);
      err = e && eof;
      din = base + 8'(i);
      @(posedge clk);
      #1;
    end
    ena = 1'b0; sof = 1'b0; eof = 1'b0; err = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int b = 0;
    while (qa.size() < n && b < 400) begin
      @(posedge clk);
      b++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string nm,
                             input int n,
                             input logic [7:0] base);
    logic [9:0] exp, got;
    vec++;
    if (qa.size() !== n) begin
      miss++;
      $display("FAIL %s beats got %0d want %0d",
               nm, qa.size(), n);
    end
    for (int i = 0; i < n; i++) begin
      exp = {(i == 0), (i == n - 1), base + 8'(i)};
      got = (i < qa.size()) ? qa[i] : 10'bx;
      vec++;
      if (got !== exp) begin
        miss++;
        $display("FAIL %s beat%0d got %h want %h",
                 nm, i, got, exp);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    vec++;
    if ({bus_a.ValOut, bus_a.SoFOut, bus_a.EoFOut,
         bus_a.DataOut, bus_a.FrameAvail,
         bus_a.Level} !== '0) begin
      miss++;
      $display("FAIL reset_a got %b %h lvl %0d want 0",
               bus_a.ValOut, bus_a.DataOut, bus_a.Level);
    end
    vec++;
    if ({bus_b.ValOut, bus_b.FrameAvail,
         bus_b.Level, bus_b.DataOut} !== '0) begin
      miss++;
      $display("FAIL reset_b got %b lvl %0d want 0",
               bus_b.ValOut, bus_b.Level);
    end
`ifdef RX_DROP_COUNT_EN
    vec++;
    if (bus_a.DropCount !== 16'd0) begin
      miss++;
      $display("FAIL reset_drop got %0d want 0",
               bus_a.DropCount);
    end
`endif
    do_reset();
  endtask

  task automatic test_good_frame();
    do_reset();
    rdy_a = 1'b1;
    send_frame(64, 8'h00, 1'b0, 1'b1);
    wait_beats(64);
    check_frame("good64", 64, 8'h00);
    vec++;
    if (ca.size() == 64 && ca[63] - ca[0] !== 63) begin
      miss++;
      $display("FAIL good64_span got %0d want 63",
               ca[63] - ca[0]);
    end
    @(negedge clk);
    vec++;
    if (bus_a.Level !== 11'd0 || bus_a.FrameAvail !== 1'b0) begin
      miss++;
      $display("FAIL good64_level got %0d want 0",
               bus_a.Level);
    end
`ifdef RX_DROP_COUNT_EN
    vec++;
    if (bus_a.DropCount !== 16'd0) begin
      miss++;
      $display("FAIL good64_drop got %0d want 0",
               bus_a.DropCount);
    end
`endif
  endtask

  task automatic test_err_frame();
    do_reset();
    rdy_a = 1'b1;
    send_frame(64, 8'h00, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    vec++;
    if (bus_a.ValOut !== 1'b0 || bus_a.Level !== 11'd0) begin
      miss++;
      $display("FAIL err_hidden got val %b lvl %0d want 0 0",
               bus_a.ValOut, bus_a.Level);
    end
    @(posedge clk);
    #1;
    send_frame(10, 8'h80, 1'b0, 1'b1);
    wait_beats(10);
    check_frame("after_err", 10, 8'h80);
`ifdef RX_DROP_COUNT_EN
    vec++;
    if (bus_a.DropCount !== 16'd1) begin
      miss++;
      $display("FAIL err_drop got %0d want 1",
               bus_a.DropCount);
    end
`endif
  endtask

  task automatic test_one_byte();
    do_reset();
    rdy_a = 1'b1;
    send_frame(1, 8'hA5, 1'b0, 1'b1);
    wait_beats(1);
    check_frame("one_byte", 1, 8'hA5);
  endtask

  task automatic test_overflow();
    do_reset();
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    send_frame(20, 8'h00, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec++;
    if (bus_b.Level !== 4'd0 || bus_b.ValOut !== 1'b0) begin
      miss++;
      $display("FAIL ovf20 got lvl %0d val %b want 0 0",
               bus_b.Level, bus_b.ValOut);
    end
`ifdef RX_DROP_COUNT_EN
    vec++;
    if (bus_b.DropCount !== 16'd1) begin
      miss++;
      $display("FAIL ovf20_drop got %0d want 1",
               bus_b.DropCount);
    end
`endif
    @(posedge clk);
    #1;
    send_frame(15, 8'h40, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec++;
    if (bus_b.Level !== 4'd15 || bus_b.FrameAvail !== 1'b1) begin
      miss++;
      $display("FAIL fit15 got lvl %0d want 15",
               bus_b.Level);
    end
    vec++;
    if ({bus_b.ValOut, bus_b.SoFOut, bus_b.EoFOut,
         bus_b.DataOut} !== {3'b110, 8'h40}) begin
      miss++;
      $display("FAIL fit15_head got %b%b%b %h want 110 40",
               bus_b.ValOut, bus_b.SoFOut, bus_b.EoFOut,
               bus_b.DataOut);
    end
    @(posedge clk);
    #1;
    send_frame(2, 8'h60, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec++;
    if (bus_b.Level !== 4'd15 || bus_b.DataOut !== 8'h40) begin
      miss++;
      $display("FAIL full_drop got lvl %0d d %h want 15 40",
               bus_b.Level, bus_b.DataOut);
    end
`ifdef RX_DROP_COUNT_EN
    vec++;
    if (bus_b.DropCount !== 16'd2) begin
      miss++;
      $display("FAIL full_drop_cnt got %0d want 2",
               bus_b.DropCount);
    end
`endif
    rdy_b = 1'b1;
    repeat (25) @(posedge clk);
    @(negedge clk);
    vec++;
    if (bus_b.Level !== 4'd0 || bus_b.ValOut !== 1'b0) begin
      miss++;
      $display("FAIL drain got lvl %0d want 0",
               bus_b.Level);
    end
    rdy_b = 1'b0;
  endtask

  task automatic test_sof_abort();
    do_reset();
    rdy_a = 1'b1;
    send_frame(5, 8'h10, 1'b0, 1'b0);
    send_frame(3, 8'h20, 1'b0, 1'b1);
    wait_beats(3);
    check_frame("sof_abort", 3, 8'h20);
`ifdef RX_DROP_COUNT_EN
    vec++;
    if (bus_a.DropCount !== 16'd1) begin
      miss++;
      $display("FAIL abort_drop got %0d want 1",
               bus_a.DropCount);
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    rdy_a = 1'b0;
    send_frame(4, 8'h30, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec++;
    if (bus_a.ValOut !== 1'b1 || bus_a.Level !== 11'd4) begin
      miss++;
      $display("FAIL pre_rst got val %b lvl %0d want 1 4",
               bus_a.ValOut, bus_a.Level);
    end
    @(posedge clk);
    #1;
    send_frame(2, 8'h50, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    vec++;
    if ({bus_a.ValOut, bus_a.Level,
         bus_a.FrameAvail} !== '0) begin
      miss++;
      $display("FAIL async_rst got val %b lvl %0d av %b want 0",
               bus_a.ValOut, bus_a.Level, bus_a.FrameAvail);
    end
    do_reset();
    rdy_a = 1'b1;
    send_frame(3, 8'h70, 1'b0, 1'b1);
    wait_beats(3);
    check_frame("post_rst", 3, 8'h70);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_err_frame();
    test_one_byte();
    test_overflow();
    test_sof_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, miss);
    $finish;
  end

endmodule
